// File: rtl/if_fetch_queue.sv
// Instruction fetch queue: circular FIFO of {pc, inst} pairs between fetch and decode.
// Optional zero-latency empty-queue bypass enabled by defining IF_FETCH_QUEUE_BYPASS_EN.
module if_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [31:0]   in_pc,
    input  logic [31:0]   in_inst,
    output logic          in_ready,
    output logic          out_valid,
    output logic [31:0]   out_pc,
    output logic [31:0]   out_inst,
    input  logic          out_ready,
    output logic [AW:0]   count
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [31:0]   r_pc_mem   [DEPTH];
    logic [31:0]   r_inst_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic w_empty;
    logic w_full;
    logic w_bypass;
    logic w_push;
    logic w_pop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_CNT);

`ifdef IF_FETCH_QUEUE_BYPASS_EN
    assign w_bypass = w_empty & in_valid & ~flush & ~rst;
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed instruction taken by decode in the same cycle never enters storage
    assign w_push = in_valid & ~w_full & ~flush & ~(w_bypass & out_ready);
    assign w_pop  = ~w_empty & out_ready & ~flush;

    assign in_ready  = ~w_full;
    assign count     = r_count;
    assign out_valid = ~w_empty | w_bypass;

    always_comb begin
        out_pc   = 32'd0;
        out_inst = 32'd0;
        if (w_bypass) begin
            out_pc   = in_pc;
            out_inst = in_inst;
        end else if (!w_empty) begin
            out_pc   = r_pc_mem[r_rd_ptr];
            out_inst = r_inst_mem[r_rd_ptr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop)
                r_count <= r_count + (AW+1)'(1);
            else if (w_pop && !w_push)
                r_count <= r_count - (AW+1)'(1);
        end
    end

    // Storage carries data only, so it is left out of reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]   <= in_pc;
            r_inst_mem[r_wr_ptr] <= in_inst;
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: queue-based reference model compared every cycle plus directed literal checks.
module tb_if_fetch_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 2;
`ifdef IF_FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_pc = 32'd0;
    logic [31:0] in_inst = 32'd0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_ready = 1'b0;
    logic [AW:0] count;

    int n_checks = 0;
    int n_fail   = 0;

    if_fetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst), .in_ready(in_ready),
        .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst), .out_ready(out_ready),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: contents of the queue, head at index 0
    logic [63:0] mq[$];
    int          msz;

    always @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            mq.delete();
        end else begin
            msz = mq.size();
            if (!(BYP && msz == 0 && in_valid && out_ready)) begin
                if (msz != 0 && out_ready)
                    void'(mq.pop_front());
                if (in_valid && msz < DEPTH)
                    mq.push_back({in_pc, in_inst});
            end
        end
    end

    logic        e_valid;
    logic [31:0] e_pc, e_inst;

    always @(negedge clk) begin
        e_valid = 1'b0;
        e_pc    = 32'd0;
        e_inst  = 32'd0;
        if (mq.size() != 0) begin
            e_valid = 1'b1;
            e_pc    = mq[0][63:32];
            e_inst  = mq[0][31:0];
        end else if (BYP && in_valid && !flush && !rst) begin
            e_valid = 1'b1;
            e_pc    = in_pc;
            e_inst  = in_inst;
        end
        chk("model out_valid", 32'(out_valid), 32'(e_valid));
        chk("model out_pc", out_pc, e_pc);
        chk("model out_inst", out_inst, e_inst);
        chk("model count", 32'(count), 32'(mq.size()));
        chk("model in_ready", 32'(in_ready), 32'(mq.size() != DEPTH));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic v, input logic [31:0] pc, input logic [31:0] inst, input logic ordy);
        in_valid  = v;
        in_pc     = pc;
        in_inst   = inst;
        out_ready = ordy;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset count", 32'(count), 32'd0);
        chk("reset out_pc", out_pc, 32'd0);
        chk("reset out_inst", out_inst, 32'd0);
        rst = 1'b0;
        tick();
        chk("post-reset in_ready", 32'(in_ready), 32'd1);

        // Streaming with decode always ready
        put(1, 32'h0, 32'h20010001, 1); tick();
`ifndef IF_FETCH_QUEUE_BYPASS_EN
        chk("stream pc0", out_pc, 32'h0);
        chk("stream inst0", out_inst, 32'h20010001);
        chk("stream count0", 32'(count), 32'd1);
`endif
        put(1, 32'h4, 32'h20020002, 1); tick();
`ifndef IF_FETCH_QUEUE_BYPASS_EN
        chk("stream pc1", out_pc, 32'h4);
`endif
        put(1, 32'h8, 32'h00221820, 1); tick();
`ifndef IF_FETCH_QUEUE_BYPASS_EN
        chk("stream inst2", out_inst, 32'h00221820);
`endif
        put(0, 32'h0, 32'h0, 1); tick();
        chk("stream drained", 32'(count), 32'd0);

        // Fill to full and apply backpressure
        for (int k = 0; k < 4; k++) begin
            put(1, 32'(4 * k), 32'hA000_0000 | 32'(k), 0);
            tick();
        end
        chk("full count", 32'(count), 32'd4);
        chk("full in_ready", 32'(in_ready), 32'd0);
        put(1, 32'h10, 32'hA000_0004, 0); tick();
        chk("full hold count", 32'(count), 32'd4);
        chk("full head", out_pc, 32'h0);
        put(1, 32'h10, 32'hA000_0004, 1); tick();
        chk("full pop count", 32'(count), 32'd3);
        chk("full pop head", out_pc, 32'h4);
        chk("full pop in_ready", 32'(in_ready), 32'd1);
        put(1, 32'h10, 32'hA000_0004, 0); tick();
        chk("full refill count", 32'(count), 32'd4);
        put(0, 32'h0, 32'h0, 1);
        repeat (4) tick();
        chk("full drained", 32'(count), 32'd0);

        // Flush with a pending push and pop
        for (int k = 0; k < 3; k++) begin
            put(1, 32'h20 + 32'(4 * k), 32'hB000_0000 | 32'(k), 0);
            tick();
        end
        chk("pre-flush count", 32'(count), 32'd3);
        flush = 1'b1;
        put(1, 32'h40, 32'hB000_0040, 1); tick();
        flush = 1'b0;
        put(0, 32'h0, 32'h0, 0);
        chk("flush count", 32'(count), 32'd0);
        chk("flush out_valid", 32'(out_valid), 32'd0);
        chk("flush in_ready", 32'(in_ready), 32'd1);
        put(1, 32'h44, 32'hB000_0044, 0); tick();
        put(0, 32'h0, 32'h0, 0);
        chk("post-flush head", out_pc, 32'h44);
        put(0, 32'h0, 32'h0, 1); tick();

        // Simultaneous push/pop across pointer wraps
        for (int k = 0; k < 10; k++) begin
            put(1, 32'h100 + 32'(4 * k), 32'hC000_0000 | 32'(k), 1);
            tick();
`ifndef IF_FETCH_QUEUE_BYPASS_EN
            chk("wrap head", out_pc, 32'h100 + 32'(4 * k));
`endif
        end
        put(0, 32'h0, 32'h0, 1); tick();
        chk("wrap drained", 32'(count), 32'd0);

        // Asynchronous reset in the middle of a cycle
        for (int k = 0; k < 3; k++) begin
            put(1, 32'h60 + 32'(4 * k), 32'hD000_0000 | 32'(k), 0);
            tick();
        end
        put(0, 32'h0, 32'h0, 0);
        chk("pre-reset count", 32'(count), 32'd3);
        #2 rst = 1'b1;
        #1;
        chk("async rst out_valid", 32'(out_valid), 32'd0);
        chk("async rst out_pc", out_pc, 32'd0);
        chk("async rst out_inst", out_inst, 32'd0);
        chk("async rst count", 32'(count), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("release in_ready", 32'(in_ready), 32'd1);
        tick();
        put(1, 32'h300, 32'hE000_0300, 0); tick();
        put(0, 32'h0, 32'h0, 1);
        chk("first after reset", out_pc, 32'h300);
        tick();
        put(0, 32'h0, 32'h0, 0);

`ifdef IF_FETCH_QUEUE_BYPASS_EN
        put(1, 32'h200, 32'hF000_0200, 1);
        #1;
        chk("bypass out_valid", 32'(out_valid), 32'd1);
        chk("bypass out_pc", out_pc, 32'h200);
        tick();
        chk("bypass count", 32'(count), 32'd0);
        put(1, 32'h204, 32'hF000_0204, 0);
        #1;
        chk("bypass stall pc", out_pc, 32'h204);
        tick();
        put(0, 32'h0, 32'h0, 0);
        chk("bypass stored", 32'(count), 32'd1);
        put(0, 32'h0, 32'h0, 1); tick();
        put(0, 32'h0, 32'h0, 0);
`endif

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
